// File: rtl/eeg_feature_if.sv
// Feature extractor stream/result bundle.
// Master drives samples and ready; slave returns the feature set.
interface eeg_feature_if #(
    parameter int DATA_W = 32
);
    logic                       in_valid;
    logic signed [DATA_W-1:0]   in_signal;
    logic                       feat_valid;
    logic                       feat_ready;
    logic [DATA_W-1:0]          feat_mav;
    logic [2*DATA_W-1:0]        feat_energy;
    logic [15:0]                feat_zc;

    modport master (
        output in_valid, in_signal, feat_ready,
        input  feat_valid, feat_mav, feat_energy, feat_zc
    );

    modport slave (
        input  in_valid, in_signal, feat_ready,
        output feat_valid, feat_mav, feat_energy, feat_zc
    );
endinterface

// File: rtl/eeg_feature_extractor.sv
// Windowed MAV / energy / zero-crossing extractor with 1-deep result buffer.
// Define FEAT_ZERO_CROSS_EN to build the zero-crossing counter.
module eeg_feature_extractor #(
    parameter int DATA_W   = 32,
    parameter int WIN_LOG2 = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    eeg_feature_if.slave bus,
    output logic         overrun
);
    localparam int AW = DATA_W + WIN_LOG2;
    localparam int SW = 2 * DATA_W + WIN_LOG2;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic [DATA_W-1:0]   x_abs;
    logic [2*DATA_W-1:0] x_sq;
    logic                s1_valid;
    logic [DATA_W-1:0]   s1_abs;
    logic [2*DATA_W-1:0] s1_sq;
    logic [AW-1:0]       acc_abs, nxt_abs;
    logic [SW-1:0]       acc_sq, nxt_sq;
    logic [WIN_LOG2-1:0] cnt;
    logic                done;
    logic [DATA_W-1:0]   res_mav;
    logic [2*DATA_W-1:0] res_energy;
    logic                feat_valid_q;
    logic [DATA_W-1:0]   mav_q;
    logic [2*DATA_W-1:0] energy_q;
    logic                run, accept, absorb, wrap, load;

    // Magnitude is unsigned so the most negative sample stays exact.
    always_comb begin
        x_abs = bus.in_signal[DATA_W-1] ? (~bus.in_signal + 1'b1)
                                        : bus.in_signal;
        x_sq    = {{DATA_W{1'b0}}, x_abs} * {{DATA_W{1'b0}}, x_abs};
        nxt_abs = acc_abs + AW'(s1_abs);
        nxt_sq  = acc_sq + SW'(s1_sq);
        run     = (state == RUN) && enable;
        accept  = run && bus.in_valid;
        absorb  = run && s1_valid;
        wrap    = absorb && (cnt == '1);
        load    = done && (!feat_valid_q || bus.feat_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            s1_valid     <= 1'b0;
            s1_abs       <= '0;
            s1_sq        <= '0;
            acc_abs      <= '0;
            acc_sq       <= '0;
            cnt          <= '0;
            done         <= 1'b0;
            res_mav      <= '0;
            res_energy   <= '0;
            feat_valid_q <= 1'b0;
            mav_q        <= '0;
            energy_q     <= '0;
            overrun      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (enable) state <= RUN;
                RUN:  if (!enable) state <= IDLE;
            endcase
            done <= wrap;
            if (!run) begin
                s1_valid <= 1'b0;
                acc_abs  <= '0;
                acc_sq   <= '0;
                cnt      <= '0;
            end else begin
                s1_valid <= bus.in_valid;
                if (accept) begin
                    s1_abs <= x_abs;
                    s1_sq  <= x_sq;
                end
                if (absorb) begin
                    cnt     <= cnt + 1'b1;
                    acc_abs <= wrap ? '0 : nxt_abs;
                    acc_sq  <= wrap ? '0 : nxt_sq;
                end
            end
            if (wrap) begin
                res_mav    <= nxt_abs[AW-1:WIN_LOG2];
                res_energy <= nxt_sq[SW-1:WIN_LOG2];
            end
            // A completed window only lands if the buffer frees this edge.
            if (load) begin
                feat_valid_q <= 1'b1;
                mav_q        <= res_mav;
                energy_q     <= res_energy;
            end else if (bus.feat_ready) begin
                feat_valid_q <= 1'b0;
            end
            if (done && !load) overrun <= 1'b1;
        end
    end

`ifdef FEAT_ZERO_CROSS_EN
    logic        prev_sign, prev_ok, s1_cross;
    logic [15:0] acc_zc, nxt_zc, res_zc, zc_q;

    always_comb begin
        nxt_zc = (s1_cross && acc_zc != 16'hFFFF) ? acc_zc + 16'd1 : acc_zc;
    end

    // Previous sign persists across windows, cleared only by leaving RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sign <= 1'b0;
            prev_ok   <= 1'b0;
            s1_cross  <= 1'b0;
            acc_zc    <= '0;
            res_zc    <= '0;
            zc_q      <= '0;
        end else begin
            if (!run) begin
                prev_ok  <= 1'b0;
                s1_cross <= 1'b0;
                acc_zc   <= '0;
            end else begin
                if (accept) begin
                    s1_cross  <= prev_ok &&
                                 (bus.in_signal[DATA_W-1] != prev_sign);
                    prev_sign <= bus.in_signal[DATA_W-1];
                    prev_ok   <= 1'b1;
                end
                if (absorb) acc_zc <= wrap ? '0 : nxt_zc;
            end
            if (wrap) res_zc <= nxt_zc;
            if (load) zc_q <= res_zc;
        end
    end

    assign bus.feat_zc = zc_q;
`else
    assign bus.feat_zc = '0;
`endif

    assign bus.feat_valid  = feat_valid_q;
    assign bus.feat_mav    = mav_q;
    assign bus.feat_energy = energy_q;
endmodule

// File: tb/tb_eeg_feature_extractor.sv
// Directed bench for eeg_feature_extractor with a result scoreboard.
// Runs 4-sample windows; zero-crossing expectations follow FEAT_ZERO_CROSS_EN.
module tb_eeg_feature_extractor;
    localparam int DATA_W   = 32;
    localparam int WIN_LOG2 = 2;
`ifdef FEAT_ZERO_CROSS_EN
    localparam bit ZC_ON = 1'b1;
`else
    localparam bit ZC_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] mav;
        logic [63:0] energy;
        logic [15:0] zc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic overrun;

    eeg_feature_if #(.DATA_W(DATA_W)) bus ();

    eeg_feature_extractor #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .bus     (bus.slave),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t e_mon;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_hs     = 0;
    bit   m_prev_ok   = 1'b0;
    bit   m_prev_sign = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [31:0] x);
        bus.in_valid  = 1'b1;
        bus.in_signal = x;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic window(input logic signed [31:0] a, b, c, d,
                          input bit push);
        logic signed [31:0] xs [4];
        logic [33:0] sa;
        logic [65:0] ss;
        longint      av;
        int          zc;
        exp_t        e;
        xs[0] = a; xs[1] = b; xs[2] = c; xs[3] = d;
        sa = '0; ss = '0; zc = 0;
        for (int i = 0; i < 4; i++) begin
            av = longint'(xs[i]);
            if (av < 0) av = -av;
            sa += 34'(av);
            ss += 66'(av) * 66'(av);
            if (m_prev_ok && (xs[i][31] != m_prev_sign)) zc++;
            m_prev_sign = xs[i][31];
            m_prev_ok   = 1'b1;
        end
        e.mav    = 32'(sa >> WIN_LOG2);
        e.energy = 64'(ss >> WIN_LOG2);
        e.zc     = ZC_ON ? 16'(zc) : 16'd0;
        if (push) sb.push_back(e);
        for (int i = 0; i < 4; i++) send(xs[i]);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        m_prev_ok = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int target);
        for (int i = 0; i < 20 && n_hs < target; i++) @(posedge clk);
        #1;
        chk(tag, 64'(n_hs), 64'(target));
    endtask

    always @(negedge clk) begin
        if (!rst && bus.feat_valid && bus.feat_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                chk("mav", 64'(bus.feat_mav), 64'(e_mon.mav));
                chk("energy", bus.feat_energy, e_mon.energy);
                chk("zc", 64'(bus.feat_zc), 64'(e_mon.zc));
            end
            n_hs++;
        end
    end

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_signal = '0;
        bus.feat_ready = 1'b0;
        #12;
        chk("rst_valid", 64'(bus.feat_valid), 64'd0);
        chk("rst_mav", 64'(bus.feat_mav), 64'd0);
        chk("rst_energy", bus.feat_energy, 64'd0);
        chk("rst_zc", 64'(bus.feat_zc), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;

        // Constant window, latency and single-cycle valid
        bus.feat_ready = 1'b1;
        window(100, 100, 100, 100, 1'b1);
        chk("t1_lat0", 64'(bus.feat_valid), 64'd0);
        @(posedge clk); #1;
        chk("t1_lat1", 64'(bus.feat_valid), 64'd0);
        @(posedge clk); #1;
        chk("t1_lat2", 64'(bus.feat_valid), 64'd1);
        @(posedge clk); #1;
        chk("t1_pulse", 64'(bus.feat_valid), 64'd0);
        chk("t1_hs", 64'(n_hs), 64'd1);

        // Alternating signs, then cross-boundary same sign
        go_idle();
        window(5, -5, 5, -5, 1'b1);
        window(-5, -5, -5, -5, 1'b1);
        wait_hs("t2_hs", 3);

        // Most negative sample
        window(32'sh8000_0000, 32'sh8000_0000,
               32'sh8000_0000, 32'sh8000_0000, 1'b1);
        wait_hs("t3_hs", 4);
        chk("t3_overrun", 64'(overrun), 64'd0);

        // Back-pressure across two windows drops the second
        bus.feat_ready = 1'b0;
        window(1, 1, 1, 1, 1'b1);
        window(3, 3, 3, 3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_valid", 64'(bus.feat_valid), 64'd1);
        chk("t4_hold", 64'(bus.feat_mav), 64'd1);
        chk("t4_overrun", 64'(overrun), 64'd1);
        bus.feat_ready = 1'b1;
        wait_hs("t4_hs", 5);
        @(posedge clk); #1;
        chk("t4_sticky", 64'(overrun), 64'd1);
        chk("t4_empty", 64'(bus.feat_valid), 64'd0);

        // Partial window discarded by enable drop
        go_idle();
        send(7);
        send(7);
        go_idle();
        window(2, 2, 2, 2, 1'b1);
        wait_hs("t5_hs", 6);

        // Asynchronous reset with a pending result
        bus.feat_ready = 1'b0;
        window(9, 9, 9, 9, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_pending", 64'(bus.feat_valid), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_valid", 64'(bus.feat_valid), 64'd0);
        chk("t6_mav", 64'(bus.feat_mav), 64'd0);
        chk("t6_energy", bus.feat_energy, 64'd0);
        chk("t6_zc", 64'(bus.feat_zc), 64'd0);
        chk("t6_overrun", 64'(overrun), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/eeg_feature_extractor.md
# eeg_feature_extractor

Windowed time-domain feature extractor that sits directly downstream of `preprocesser_top`. It consumes the filtered 32-bit signed EEG stream and, for every window of 2^WIN_LOG2 accepted samples, produces three features:
- mean absolute value
- mean energy
- zero-crossing count

Results are presented to the classifier through a valid/ready handshake with a one-deep output buffer. Accumulation of the next window proceeds while a result waits.

## Interface
- `DATA_W`, 32: input sample width, signed two's complement
- `WIN_LOG2`, 8: log2 of window length (window = 256 samples)
- `clk` in 1: system clock (same `clk` as `preprocesser_top`)
- `rst` in 1: asynchronous, active-high reset
- `enable` in 1: run control; low discards any partial window
- `in_valid` in 1: single-cycle strobe, `in_signal` holds a new filtered sample (one per sampling period)
- `in_signal` in DATA_W: filtered sample from `preprocesser_top.out_signal`
- `feat_valid` out 1: feature set available
- `feat_ready` in 1: consumer accepts feature set
- `feat_mav` out DATA_W: unsigned, sum(|x|) >> WIN_LOG2
- `feat_energy` out 2*DATA_W: unsigned, sum(x²) >> WIN_LOG2
- `feat_zc` out 16: zero crossings in window
- `overrun` out 1: sticky, a completed window was dropped

## Operation
- **States:**
  - **IDLE:** entered on reset or when `enable` is low. Accumulators, sample counter and pipeline cleared; previous-sample flag invalid. Go to RUN when `enable` is high.
  - **RUN:** accept samples on `in_valid`. `enable` low returns to IDLE at the next edge and discards the partial window.
- **Pipeline stage 1:** on `in_valid`, register |x| (DATA_W unsigned, so |−2^(DATA_W−1)| is exact), x² (2*DATA_W unsigned), and the crossing bit.
- **Pipeline stage 2:** add into `acc_abs` (DATA_W+WIN_LOG2 bits) and `acc_sq` (2*DATA_W+WIN_LOG2 bits); no overflow is possible. Increment the sample counter (WIN_LOG2 bits, wraps).
- **Crossing rule:** crossing = sign(x) ≠ sign(previous accepted sample), where sign is x<0. It is not counted for the first sample after IDLE. The previous sample carries across window boundaries.
- **Window completion:** when stage 2 absorbs the sample with counter = 2^WIN_LOG2−1:
  - Shifted results are loaded into the output registers if the output buffer is empty.
  - Accumulators clear in the same cycle, so the next sample starts a new window with no lost samples.
  - If the buffer is still full (`feat_valid`=1, not handshaking this cycle), the new result is dropped and `overrun` is set. `overrun` clears only on `rst`.
  - A handshake in the same cycle as completion frees the buffer, and the new result loads.
- **Handshake:** transfer occurs when `feat_valid` & `feat_ready` at a rising edge. Outputs are held stable while `feat_valid`=1 and `feat_ready`=0. `feat_valid` is independent of `feat_ready`.
- A pending result survives a drop of `enable`; it is cleared only by handshake or `rst`.

## Timing
- **Reset values:** all outputs reset to 0 (`feat_valid`, `feat_mav`, `feat_energy`, `feat_zc`, `overrun`); state resets to IDLE.
- **Latency:** `feat_valid` rises 2 clk cycles after the edge sampling the window's final `in_valid`.
- Back-to-back `in_valid` (every cycle) is supported at full rate.
- **`rst` mid-window:** asynchronous clear of everything; the partial window is lost.
- **`in_valid` in IDLE:** ignored.
- **`in_valid` on the cycle `enable` falls:** ignored.

## Configuration
- `FEAT_ZERO_CROSS_EN` defined: the crossing logic and `feat_zc` counter (saturating at 16'hFFFF) are built.
- Undefined: no crossing logic; `feat_zc` is tied to 0 and the previous-sample register is omitted. MAV and energy are unaffected.

## Test plan
Bench uses WIN_LOG2=2 (4-sample windows) with `FEAT_ZERO_CROSS_EN` defined, unless a scenario says otherwise.
- Four samples of 100, `feat_ready`=1 → `feat_mav`=100, `feat_energy`=10000, `feat_zc`=0; `feat_valid` high exactly one cycle, 2 cycles after the 4th `in_valid`.
- Samples +5, −5, +5, −5 after IDLE → `feat_mav`=5, `feat_energy`=25, `feat_zc`=3. A following window of −5, −5, −5, −5 → `feat_zc`=0 (the cross-boundary comparison, −5 then −5, gives no crossing).
- Four samples of −2147483648 → `feat_mav`=2147483648, `feat_energy`=2^62.
- `feat_ready`=0 across two full windows (1,1,1,1 then 3,3,3,3) → outputs hold `feat_mav`=1; the second window is dropped; `overrun`=1 and stays 1 after `feat_ready` rises.
- Two samples of 7, `enable` low for 1 cycle, then four samples of 2 → `feat_mav`=2, `feat_zc`=0 (partial window discarded).
- Assert `rst` asynchronously mid-window with `feat_valid`=1 → all outputs 0 immediately, before the next `clk` edge.
